// File: rtl/transmitter_if.sv
// Byte-write handshake and serial line outputs of the UART transmitter.
// The master drives writes; the slave (transmitter) reports line state.
interface transmitter_if;
  logic [7:0] d_in;
  logic       tx_start;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output d_in, tx_start,
    input  tx_ready, tx, busy, tx_done
  );

  modport slave (
    input  d_in, tx_start,
    output tx_ready, tx, busy, tx_done
  );
endinterface

// File: rtl/transmitter.sv
// UART transmitter: 8N1/8N2 framing with a one-byte holding buffer so that
// back-to-back frames go out with no idle cycles in between.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line high, waiting for an accepted write
// S_START | start bit (0) on the line
// S_DATA  | data bits, LSB first, bit_cnt selects the position
// S_STOP  | stop bits (1), stop_cnt selects the position
module transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 2
) (
  input  logic clk1,
  input  logic reset,
  transmitter_if.slave bus
);

  localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic            stop_q, stop_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            accept;
  logic            baud_last;
  logic            direct_load;

  assign accept    = bus.tx_start && !buf_full_q;
  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge clk1) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    direct_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d     = bus.d_in;
          baud_d      = '0;
          tx_d        = 1'b0;
          state_d     = S_START;
          direct_load = 1'b1;
        end
      end

      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            done_d = 1'b1;
            stop_d = 1'b0;
            if (buf_full_q) begin
              shift_d    = buf_q;
              buf_full_d = 1'b0;
              tx_d       = 1'b0;
              state_d    = S_START;
            end else if (accept) begin
              // A write landing on the final stop edge with an empty buffer
              // goes straight onto the line rather than stranding in the buffer.
              shift_d     = bus.d_in;
              tx_d        = 1'b0;
              state_d     = S_START;
              direct_load = 1'b1;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (accept && !direct_load) begin
      buf_d      = bus.d_in;
      buf_full_d = 1'b1;
    end
  end

  assign bus.tx_ready = !buf_full_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for transmitter: the reference model is the expected
// line waveform kept as a queue of per-cycle bit values built from each accepted byte.
module tb_transmitter;

  localparam int CPB   = 16;
  localparam int SB    = 2;
  localparam int NBITS = 9 + SB;
  localparam int FRAME = NBITS * CPB;

  logic clk1 = 1'b0;
  logic reset;

  always #10 clk1 = ~clk1;

  transmitter_if bus ();

  transmitter #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (SB)
  ) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus.slave)
  );

  int          n_checks  = 0;
  int          n_errors  = 0;
  int unsigned cyc       = 0;
  int          done_cnt  = 0;
  bit          seen_done = 1'b0;

  bit line_q[$];
  bit last_q[$];
  bit cur_last  = 1'b0;
  bit exp_tx    = 1'b1;
  bit exp_busy  = 1'b0;
  bit exp_done  = 1'b0;
  bit exp_ready = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] b);
    bit v;
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k <= 8) v = b[k-1];
      else             v = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        line_q.push_back(v);
        last_q.push_back((k == NBITS - 1) && (c == CPB - 1));
      end
    end
  endfunction

  // Queue holds bits still to be shown; more than one frame's worth means a byte is buffered.
  function automatic void model_edge(input bit rst, input bit start, input logic [7:0] din);
    if (rst) begin
      line_q.delete();
      last_q.delete();
      cur_last  = 1'b0;
      exp_tx    = 1'b1;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      exp_ready = 1'b1;
      return;
    end
    exp_done = cur_last;
    if (start && (line_q.size() < FRAME))
      push_frame(din);
    if (line_q.size() > 0) begin
      exp_tx   = line_q.pop_front();
      cur_last = last_q.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      cur_last = 1'b0;
      exp_busy = 1'b0;
    end
    exp_ready = (line_q.size() < FRAME);
  endfunction

  task automatic step(input bit rst, input bit start, input logic [7:0] din);
    reset        = rst;
    bus.tx_start = start;
    bus.d_in     = din;
    @(posedge clk1);
    model_edge(rst, start, din);
    cyc++;
    @(negedge clk1);
    check_eq("tx",       bus.tx,       exp_tx);
    check_eq("busy",     bus.busy,     exp_busy);
    check_eq("tx_done",  bus.tx_done,  exp_done);
    check_eq("tx_ready", bus.tx_ready, exp_ready);
    seen_done = bus.tx_done;
    if (bus.tx_done) done_cnt++;
  endtask

  task automatic run_until_done(input int budget, output int taken);
    taken = 0;
    do begin
      step(1'b0, 1'b0, 8'($urandom));
      taken++;
    end while (!seen_done && taken < budget);
    check_eq("done_within_budget", seen_done, 1'b1);
  endtask

  initial begin
    int t;
    reset        = 1'b1;
    bus.tx_start = 1'b0;
    bus.d_in     = 8'h00;

    // reset with a simultaneous write: the write must be dropped
    step(1'b1, 1'b1, 8'h55);
    step(1'b1, 1'b1, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    check_eq("reset_tx", bus.tx, 1'b1);

    // single frame 0x75 from idle; d_in scrambled afterwards
    done_cnt = 0;
    step(1'b0, 1'b1, 8'h75);
    run_until_done(FRAME + 20, t);
    check_eq("frame_len_75", t, FRAME);
    check_eq("busy_falls_with_done", bus.busy, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'($urandom));
    check_eq("done_count_75", done_cnt, 1);

    // 0x0F then 0xA5 buffered, third write ignored
    done_cnt = 0;
    step(1'b0, 1'b1, 8'h0F);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hA5);
    check_eq("ready_low_buffered", bus.tx_ready, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hC3);
    run_until_done(FRAME + 20, t);
    check_eq("frame1_len", t + 17, FRAME);
    run_until_done(FRAME + 20, t);
    check_eq("done_gap", t, FRAME);
    for (int i = 0; i < 2 * FRAME; i++) step(1'b0, 1'b0, 8'($urandom));
    check_eq("done_count_pair", done_cnt, 2);

    // reset at cycle 100 of a 0x75 frame with 0x33 buffered
    done_cnt = 0;
    step(1'b0, 1'b1, 8'h75);
    step(1'b0, 1'b1, 8'h33);
    for (int i = 0; i < 98; i++) step(1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 8'h00);
    check_eq("abort_tx", bus.tx, 1'b1);
    check_eq("abort_ready", bus.tx_ready, 1'b1);
    for (int i = 0; i < 2 * FRAME + 20; i++) step(1'b0, 1'b0, 8'($urandom));
    check_eq("abort_no_done", done_cnt, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 20000; i++)
      step(($urandom_range(0, 3999) == 0), ($urandom_range(0, 39) == 0), 8'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
